// File: rtl/pcileech_tlp_pio_responder_pkg.sv
// Shared TLP codes, completion constants, FSM state type and byte-enable helpers
// for the BAR-backed PIO responder.
package pcileech_tlp_pio_responder_pkg;

    localparam logic [7:0]  TLP_FMT_MRD32 = 8'h00;
    localparam logic [7:0]  TLP_FMT_MWR32 = 8'h40;
    localparam logic [31:0] CPLD_DW0      = 32'h4A00_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_TX0,
        ST_TX1,
        ST_SKIP
    } pio_state_t;

    function automatic logic [1:0] be_low_index(input logic [3:0] be);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (be[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] be_high_index(input logic [3:0] be);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Span from lowest to highest enabled byte; an empty mask collapses to 1.
    function automatic logic [11:0] be_byte_count(input logic [3:0] be);
        logic [2:0] span;
        span = {1'b0, be_high_index(be)} - {1'b0, be_low_index(be)} + 3'd1;
        return {9'd0, span};
    endfunction

endpackage

// File: rtl/pcileech_pio_bram32.sv
// 32-bit wide register array: one byte-enabled write port, one read port with
// a single cycle of registered read latency.
module pcileech_pio_bram32 #(
    parameter int DEPTH_DW = 256,
    parameter int AW       = $clog2(DEPTH_DW)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_DW];
        logic [7:0] rd_lane_reg;

        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                mem[wr_addr] <= wr_data[8*gi +: 8];
            end
            if (rd_en) begin
                rd_lane_reg <= mem[rd_addr];
            end
        end

        assign rd_data[8*gi +: 8] = rd_lane_reg;
    end

endmodule

// File: rtl/pcileech_tlp_pio_responder.sv
// Snoops RX TLPs and answers single-DW MRd32/MWr32 hitting BAR0 from a local
// register array, returning two-beat CplD TLPs on the TX side.
module pcileech_tlp_pio_responder
    import pcileech_tlp_pio_responder_pkg::*;
#(
    parameter int DEPTH_DW = 256
) (
    input  logic        clk_pcie,
    input  logic        rst,
    input  logic [63:0] rx_data,
    input  logic [7:0]  rx_keep,
    input  logic        rx_last,
    input  logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] base_address_register,
    input  logic [15:0] completer_id,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_keep,
    output logic        tx_last,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH_DW);

    pio_state_t state_reg, state_next;

    logic          rx_sop_reg;
    logic [7:0]    fmt_type_reg;
    logic [2:0]    tc_reg;
    logic [1:0]    attr_reg;
    logic          len_ok_reg;
    logic [15:0]   rid_reg;
    logic [7:0]    tag_reg;
    logic [3:0]    be_reg;
    logic [4:0]    addr_lo_reg;
    logic [AW-1:0] index_reg;

    logic          wr_en_reg;
    logic [3:0]    wr_be_reg;
    logic [AW-1:0] wr_index_reg;
    logic [31:0]   wr_data_reg;

    logic          drop_pend_reg;
    logic [15:0]   drop_count_reg;

    logic          rx_xfer;
    logic          beat0;
    logic          accept;
    logic          hdr_xfer;
    logic          addr_hit;
    logic          hdr_qual;
    logic          beat0_qual;
    logic          wr_fire;
    logic [31:0]   rd_data;
    logic [31:0]   cpl_dw0;
    logic [31:0]   cpl_dw1;
    logic [31:0]   cpl_dw2;
    logic          unused_bits;

    assign rx_xfer  = rx_valid & rx_ready;
    assign beat0    = rx_xfer & rx_sop_reg;
    // A new TLP may start in the same cycle the completion finishes.
    assign accept   = beat0 & ((state_reg == ST_IDLE) | ((state_reg == ST_TX1) & tx_ready));
    assign hdr_xfer = (state_reg == ST_HDR) & rx_xfer;
    assign addr_hit = (rx_data[31:12] == base_address_register[31:12]);
    assign hdr_qual = ((fmt_type_reg == TLP_FMT_MRD32) | (fmt_type_reg == TLP_FMT_MWR32))
                      & len_ok_reg & addr_hit;
    assign beat0_qual = ((rx_data[31:24] == TLP_FMT_MRD32) | (rx_data[31:24] == TLP_FMT_MWR32))
                        & (rx_data[9:0] == 10'd1);
    assign wr_fire  = hdr_xfer & hdr_qual & (fmt_type_reg == TLP_FMT_MWR32)
                      & (rx_keep[7:4] == 4'hf);

    assign unused_bits = &{1'b0, rx_data, rx_keep[3:0], base_address_register[11:0]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (beat0 && !rx_last) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (rx_xfer) begin
                    if (hdr_qual && fmt_type_reg == TLP_FMT_MRD32) state_next = ST_RD;
                    else if (rx_last)                             state_next = ST_IDLE;
                    else                                          state_next = ST_SKIP;
                end
            end
            ST_RD:   state_next = ST_TX0;
            ST_TX0: begin
                if (tx_ready) state_next = ST_TX1;
            end
            ST_TX1: begin
                if (tx_ready) state_next = (beat0 && !rx_last) ? ST_HDR : ST_IDLE;
            end
            ST_SKIP: begin
                if (rx_xfer && rx_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rx_sop_reg   <= 1'b1;
            fmt_type_reg <= '0;
            tc_reg       <= '0;
            attr_reg     <= '0;
            len_ok_reg   <= 1'b0;
            rid_reg      <= '0;
            tag_reg      <= '0;
            be_reg       <= '0;
            addr_lo_reg  <= '0;
            index_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (rx_xfer) rx_sop_reg <= rx_last;
            if (accept) begin
                fmt_type_reg <= rx_data[31:24];
                tc_reg       <= rx_data[22:20];
                attr_reg     <= rx_data[13:12];
                len_ok_reg   <= (rx_data[9:0] == 10'd1);
                rid_reg      <= rx_data[63:48];
                tag_reg      <= rx_data[47:40];
                be_reg       <= rx_data[35:32];
            end
            if (hdr_xfer) begin
                addr_lo_reg <= rx_data[6:2];
                index_reg   <= rx_data[AW+1:2];
            end
        end
    end

    // Write data is registered so the array sees it in the cycle after beat 1.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            wr_en_reg    <= 1'b0;
            wr_be_reg    <= '0;
            wr_index_reg <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_en_reg <= wr_fire;
            if (wr_fire) begin
                wr_be_reg    <= be_reg;
                wr_index_reg <= rx_data[AW+1:2];
                wr_data_reg  <= rx_data[63:32];
            end
        end
    end

    // Requests arriving while busy are tracked just far enough to see the address.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            drop_pend_reg  <= 1'b0;
            drop_count_reg <= '0;
        end else if (beat0 && !accept) begin
            drop_pend_reg <= beat0_qual & ~rx_last;
        end else if (rx_xfer && drop_pend_reg) begin
            drop_pend_reg <= 1'b0;
            if (addr_hit && drop_count_reg != 16'hffff) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    assign drop_count = drop_count_reg;

    pcileech_pio_bram32 #(
        .DEPTH_DW (DEPTH_DW),
        .AW       (AW)
    ) u_bram (
        .clk     (clk_pcie),
        .wr_en   (wr_en_reg),
        .wr_be   (wr_be_reg),
        .wr_addr (wr_index_reg),
        .wr_data (wr_data_reg),
        .rd_en   (state_reg == ST_RD),
        .rd_addr (index_reg),
        .rd_data (rd_data)
    );

    assign cpl_dw0 = CPLD_DW0 | {9'd0, tc_reg, 6'd0, attr_reg, 12'd0};
    assign cpl_dw1 = {completer_id, 3'b000, 1'b0, be_byte_count(be_reg)};
    assign cpl_dw2 = {rid_reg, tag_reg, 1'b0, addr_lo_reg, be_low_index(be_reg)};

    always_comb begin
        tx_data  = '0;
        tx_keep  = '0;
        tx_last  = 1'b0;
        tx_valid = 1'b0;
        case (state_reg)
            ST_TX0: begin
                tx_data  = {cpl_dw1, cpl_dw0};
                tx_keep  = 8'hff;
                tx_valid = 1'b1;
            end
            ST_TX1: begin
                tx_data  = {rd_data, cpl_dw2};
                tx_keep  = 8'hff;
                tx_last  = 1'b1;
                tx_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcileech_tlp_pio_responder.sv
// Directed bench: table of MRd/MWr requests with hand-computed completions, plus
// sequences for back-to-back TLPs, TX backpressure with a dropped request, and reset.
module tb_pcileech_tlp_pio_responder;

    localparam logic [31:0] BAR = 32'hF7C0_0000;
    localparam logic [15:0] CID = 16'h0100;
    localparam logic [15:0] RID = 16'h1234;

    logic        clk_pcie = 1'b0;
    logic        rst      = 1'b1;
    logic [63:0] rx_data  = '0;
    logic [7:0]  rx_keep  = '0;
    logic        rx_last  = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready = 1'b1;
    logic        tx_ready = 1'b1;
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_last;
    logic        tx_valid;
    logic [15:0] drop_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_pcie = ~clk_pcie;

    pcileech_tlp_pio_responder #(.DEPTH_DW(256)) dut (
        .clk_pcie              (clk_pcie),
        .rst                   (rst),
        .rx_data               (rx_data),
        .rx_keep               (rx_keep),
        .rx_last               (rx_last),
        .rx_valid              (rx_valid),
        .rx_ready              (rx_ready),
        .base_address_register (BAR),
        .completer_id          (CID),
        .tx_data               (tx_data),
        .tx_keep               (tx_keep),
        .tx_last               (tx_last),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .drop_count            (drop_count)
    );

    typedef struct {
        logic [7:0]  fmt;
        logic [9:0]  len;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [7:0]  tag;
        logic [31:0] wdata;
        logic        exp_cpl;
        logic [63:0] exp_b0;
        logic [63:0] exp_b1;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [7:0] fmt, input logic [9:0] len,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [2:0] tc, input logic [1:0] attr,
                                input logic [7:0] tag, input logic [31:0] wdata,
                                input logic exp_cpl, input logic [63:0] exp_b0,
                                input logic [63:0] exp_b1);
        vec_t v;
        v.fmt = fmt; v.len = len; v.addr = addr; v.be = be; v.tc = tc;
        v.attr = attr; v.tag = tag; v.wdata = wdata; v.exp_cpl = exp_cpl;
        v.exp_b0 = exp_b0; v.exp_b1 = exp_b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic send_tlp(input logic [7:0] fmt, input logic [9:0] len,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [2:0] tc, input logic [1:0] attr,
                            input logic [7:0] tag, input logic [31:0] wdata);
        @(posedge clk_pcie); #1;
        rx_valid = 1'b1;
        rx_data  = {RID, tag, 4'h0, be, fmt, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, len};
        rx_keep  = 8'hff;
        rx_last  = 1'b0;
        @(posedge clk_pcie); #1;
        rx_data  = {wdata, addr};
        rx_keep  = (fmt == 8'h40) ? 8'hff : 8'h0f;
        rx_last  = 1'b1;
        @(posedge clk_pcie); #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = '0;
        rx_keep  = '0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_pcie);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_cpl(input string name, input logic [63:0] b0, input logic [63:0] b1);
        bit ok;
        wait_valid(ok);
        check({name, " cpl seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        check({name, " b0 data"}, tx_data, b0);
        check({name, " b0 keep/last"}, {55'd0, tx_keep, tx_last}, {55'd0, 8'hff, 1'b0});
        @(negedge clk_pcie);
        check({name, " b1 data"}, tx_data, b1);
        check({name, " b1 valid/keep/last"}, {54'd0, tx_valid, tx_keep, tx_last},
              {54'd0, 1'b1, 8'hff, 1'b1});
        @(negedge clk_pcie);
        check({name, " idle after"}, 64'(tx_valid), 64'd0);
    endtask

    task automatic expect_none(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_pcie);
            if (tx_valid) seen = 1'b1;
        end
        check({name, " no cpl"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        bit          ok;
        int          unstable;

        vecs[0]  = mk(8'h40, 10'd1, BAR + 32'h10,  4'hF, 3'd0, 2'd0, 8'h00, 32'hDEADBEEF, 1'b0, 64'h0, 64'h0);
        vecs[1]  = mk(8'h00, 10'd1, BAR + 32'h10,  4'hF, 3'd0, 2'd0, 8'h05, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_0510);
        vecs[2]  = mk(8'h40, 10'd1, BAR + 32'h20,  4'hF, 3'd0, 2'd0, 8'h00, 32'h11223344, 1'b0, 64'h0, 64'h0);
        vecs[3]  = mk(8'h40, 10'd1, BAR + 32'h20,  4'h6, 3'd0, 2'd0, 8'h00, 32'h99AABB77, 1'b0, 64'h0, 64'h0);
        vecs[4]  = mk(8'h00, 10'd1, BAR + 32'h20,  4'hF, 3'd0, 2'd0, 8'h06, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'h11AA_BB44_1234_0620);
        vecs[5]  = mk(8'h00, 10'd1, BAR + 32'h20,  4'h2, 3'd0, 2'd0, 8'h07, 32'h0, 1'b1,
                      64'h0100_0001_4A00_0001, 64'h11AA_BB44_1234_0721);
        vecs[6]  = mk(8'h00, 10'd1, BAR + 32'h20,  4'hA, 3'd3, 2'd2, 8'h08, 32'h0, 1'b1,
                      64'h0100_0003_4A30_2001, 64'h11AA_BB44_1234_0821);
        vecs[7]  = mk(8'h00, 10'd1, 32'hF7C0_1010, 4'hF, 3'd0, 2'd0, 8'h10, 32'h0, 1'b0, 64'h0, 64'h0);
        vecs[8]  = mk(8'h20, 10'd1, BAR + 32'h10,  4'hF, 3'd0, 2'd0, 8'h11, 32'h0, 1'b0, 64'h0, 64'h0);
        vecs[9]  = mk(8'h00, 10'd2, BAR + 32'h10,  4'hF, 3'd0, 2'd0, 8'h12, 32'h0, 1'b0, 64'h0, 64'h0);
        vecs[10] = mk(8'h00, 10'd1, BAR + 32'h10,  4'h9, 3'd0, 2'd0, 8'h09, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_0910);
        vecs[11] = mk(8'h00, 10'd1, BAR + 32'h410, 4'hF, 3'd0, 2'd0, 8'h0A, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_0A10);
        vecs[12] = mk(8'h40, 10'd1, BAR + 32'h7FC, 4'hF, 3'd0, 2'd0, 8'h00, 32'hCAFEF00D, 1'b0, 64'h0, 64'h0);
        vecs[13] = mk(8'h00, 10'd1, BAR + 32'h3FC, 4'hF, 3'd0, 2'd0, 8'h0B, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'hCAFE_F00D_1234_0B7C);
        vecs[14] = mk(8'h40, 10'd1, 32'hF7C0_1010, 4'hF, 3'd0, 2'd0, 8'h00, 32'h55555555, 1'b0, 64'h0, 64'h0);
        vecs[15] = mk(8'h00, 10'd1, BAR + 32'h10,  4'hF, 3'd0, 2'd0, 8'h0C, 32'h0, 1'b1,
                      64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_0C10);

        // Reset state
        repeat (3) @(posedge clk_pcie);
        @(negedge clk_pcie);
        check("reset tx_data", tx_data, 64'h0);
        check("reset valid/keep/last", {55'd0, tx_valid, tx_keep}, 64'h0);
        check("reset tx_last", 64'(tx_last), 64'h0);
        check("reset drop_count", 64'(drop_count), 64'h0);
        @(posedge clk_pcie); #1;
        rst = 1'b0;

        // Table-driven requests
        for (int i = 0; i < 16; i++) begin
            send_tlp(vecs[i].fmt, vecs[i].len, vecs[i].addr, vecs[i].be,
                     vecs[i].tc, vecs[i].attr, vecs[i].tag, vecs[i].wdata);
            if (vecs[i].exp_cpl) expect_cpl($sformatf("v%0d", i), vecs[i].exp_b0, vecs[i].exp_b1);
            else                 expect_none($sformatf("v%0d", i));
        end
        check("table drop_count", 64'(drop_count), 64'h0);

        // Back-to-back: second beat 0 lands on the TX1 handshake cycle
        fork
            begin
                send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h11, 32'h0);
                @(posedge clk_pcie);
                send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h12, 32'h0);
            end
            begin
                expect_cpl("b2b first", 64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_1110);
                expect_cpl("b2b second", 64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_1210);
            end
        join
        check("b2b drop_count", 64'(drop_count), 64'h0);

        // TX backpressure for 20 cycles while a second MRd is dropped
        tx_ready = 1'b0;
        send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h21, 32'h0);
        wait_valid(ok);
        check("stall cpl seen", 64'(ok), 64'd1);
        held = tx_data;
        check("stall b0 data", held, 64'h0100_0004_4A00_0001);
        send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h22, 32'h0);
        unstable = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_pcie);
            if (tx_data !== held || tx_valid !== 1'b1 || tx_last !== 1'b0) unstable++;
        end
        check("stall hold stable", 64'(unstable), 64'd0);
        check("stall drop_count", 64'(drop_count), 64'd1);
        tx_ready = 1'b1;
        @(negedge clk_pcie);
        check("stall b1 data", tx_data, 64'hDEAD_BEEF_1234_2110);
        check("stall b1 last", 64'(tx_last), 64'd1);
        @(negedge clk_pcie);
        check("stall idle after", 64'(tx_valid), 64'd0);
        expect_none("stall single cpl");

        // Reset asserted while TX1 is stalled
        tx_ready = 1'b0;
        send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h30, 32'h0);
        wait_valid(ok);
        check("rst cpl seen", 64'(ok), 64'd1);
        tx_ready = 1'b1;
        @(posedge clk_pcie); #1;
        tx_ready = 1'b0;
        @(negedge clk_pcie);
        check("rst in TX1", {62'd0, tx_valid, tx_last}, 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst async valid", 64'(tx_valid), 64'd0);
        check("rst async data", tx_data, 64'h0);
        check("rst drop_count", 64'(drop_count), 64'h0);
        repeat (2) @(posedge clk_pcie);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        send_tlp(8'h00, 10'd1, BAR + 32'h10, 4'hF, 3'd0, 2'd0, 8'h31, 32'h0);
        expect_cpl("post-rst", 64'h0100_0004_4A00_0001, 64'hDEAD_BEEF_1234_3110);
        check("post-rst drop_count", 64'(drop_count), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
